// File: rtl/spy_seg_capture.sv
// spy_seg_capture: arms on command, then captures up to num_seg triggered
// segments of seg_depth words into one linear spy RAM (no wrap; stops on full).
// Optional feature: define SPY_TRIG_DROP_CNT_EN to add the 16-bit drop_cnt
// output counting trigger edges that arrive while a segment is in progress.
module spy_seg_capture #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned SEG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              disarm,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  trig_delay,
  input  logic [CNT_W-1:0]  seg_depth,
  input  logic [SEG_W-1:0]  num_seg,
  output logic              wren,
  output logic [ADDR_W-1:0] waddr,
  output logic [SEG_W-1:0]  seg_idx,
  output logic [ADDR_W:0]   words,
  output logic              busy,
  output logic              done,
  output logic              full
`ifdef SPY_TRIG_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int unsigned WORDS_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]  ADDR_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [SEG_W-1:0]   SEG_ONE  = SEG_W'(1);
  localparam logic [WORDS_W-1:0] WORD_ONE = WORDS_W'(1);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, WRITE, DONE} state_t;

  state_t            state;
  logic              trig_d;
  logic [CNT_W-1:0]  delay_l;
  logic [CNT_W-1:0]  depth_l;
  logic [SEG_W-1:0]  nseg_l;
  logic [CNT_W-1:0]  delay_cnt;
  logic [CNT_W-1:0]  mem_cnt;

  logic trig_rise;
  logic arm_ok;
  logic at_top;
  logic arm_acc;

  assign trig_rise = trig_in & ~trig_d;
  assign arm_ok    = arm && (seg_depth != '0) && (num_seg != '0);
  // the write just presented was to the last RAM address
  assign at_top    = wren && (waddr == ADDR_MAX);
  // arm that actually starts a run (disarm wins in DONE)
  assign arm_acc   = arm_ok && ((state == IDLE) || ((state == DONE) && !disarm));

  // capture control: state, write port and run status
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      trig_d    <= 1'b0;
      wren      <= 1'b0;
      waddr     <= '0;
      seg_idx   <= '0;
      words     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      full      <= 1'b0;
      delay_l   <= '0;
      depth_l   <= '0;
      nseg_l    <= '0;
      delay_cnt <= '0;
      mem_cnt   <= '0;
    end else begin
      trig_d <= trig_in;
      wren   <= 1'b0;
      if (disarm && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm_ok) begin
              delay_l <= trig_delay;
              depth_l <= seg_depth;
              nseg_l  <= num_seg;
              waddr   <= '0;
              words   <= '0;
              seg_idx <= '0;
              done    <= 1'b0;
              full    <= 1'b0;
              busy    <= 1'b1;
              state   <= ARMED;
            end
          end
          ARMED: begin
            if (trig_rise) begin
              mem_cnt <= '0;
              if (delay_l == '0) begin
                state <= WRITE;
              end else begin
                delay_cnt <= CNT_ONE;
                state     <= DELAY;
              end
            end
          end
          DELAY: begin
            if (delay_cnt == delay_l) begin
              state <= WRITE;
            end else begin
              delay_cnt <= delay_cnt + CNT_ONE;
            end
          end
          WRITE: begin
            if (at_top) begin
              // RAM end: stop the run, count the segment only if it completed
              full  <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
              if (mem_cnt == depth_l) seg_idx <= seg_idx + SEG_ONE;
            end else if (mem_cnt == depth_l) begin
              seg_idx <= seg_idx + SEG_ONE;
              if ((seg_idx + SEG_ONE) == nseg_l) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                state <= ARMED;
              end
            end else begin
              // words doubles as the next linear write address
              wren    <= 1'b1;
              waddr   <= words[ADDR_W-1:0];
              words   <= words + WORD_ONE;
              mem_cnt <= mem_cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPY_TRIG_DROP_CNT_EN
  // count trigger edges that land while a segment is delaying or writing
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (arm_acc) begin
      drop_cnt <= '0;
    end else if (trig_rise && ((state == DELAY) || (state == WRITE)) &&
                 (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spy_seg_capture.sv
// Scoreboard bench for spy_seg_capture: an event-level model predicts every
// RAM write (edge number and address) and the settled run status.
module tb_spy_seg_capture;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SEG_W  = 4;
  localparam int MAXA = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              reset, arm, disarm, trig_in;
  logic [CNT_W-1:0]  trig_delay, seg_depth;
  logic [SEG_W-1:0]  num_seg;
  logic              wren;
  logic [ADDR_W-1:0] waddr;
  logic [SEG_W-1:0]  seg_idx;
  logic [ADDR_W:0]   words;
  logic              busy, done, full;
`ifdef SPY_TRIG_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  always #5 clk = ~clk;

  spy_seg_capture #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .SEG_W(SEG_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .trig_in(trig_in),
    .trig_delay(trig_delay), .seg_depth(seg_depth), .num_seg(num_seg),
    .wren(wren), .waddr(waddr), .seg_idx(seg_idx), .words(words),
    .busy(busy), .done(done), .full(full)
`ifdef SPY_TRIG_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  typedef struct { int e; int a; } wr_t;
  wr_t q[$];
  wr_t mon_w;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  // reference model state (event level)
  bit m_run, m_fin, m_full, m_seg_cnt, m_seg_full;
  int m_delay, m_depth, m_nseg, m_ready, m_done_edge;
  int m_words, m_segs, m_drop, m_seg_lo, m_seg_hi;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_fin = 0; m_full = 0; m_seg_cnt = 0; m_seg_full = 0;
    m_words = 0; m_segs = 0; m_drop = 0; m_seg_lo = 0; m_seg_hi = 0;
    m_ready = 0; m_done_edge = 0;
  endtask

  task automatic model_arm(input int e, input int d, input int dep, input int ns);
    bit idle;
    idle = !m_run || (m_fin && e > m_done_edge);
    if (idle && dep != 0 && ns != 0) begin
      model_clear();
      m_run = 1; m_delay = d; m_depth = dep; m_nseg = ns; m_ready = e + 1;
    end
  endtask

  // trigger rising edge sampled at edge e
  task automatic model_trig(input int e);
    int k, last;
    bit hit;
    wr_t w;
    if (m_run && !m_fin && e >= m_ready) begin
      k = 0; hit = 0; last = e;
      while (k < m_depth && !hit) begin
        w.e = e + m_delay + 1 + k;
        w.a = m_words & MAXA;
        q.push_back(w);
        last = w.e;
        m_words++;
        k++;
        if (w.a == MAXA) hit = 1;
      end
      m_seg_lo = e; m_seg_hi = last + 1;
      m_seg_cnt = (k == m_depth); m_seg_full = hit;
      if (m_seg_cnt) m_segs++;
      if (hit) m_full = 1;
      if (hit || m_segs == m_nseg) begin
        m_fin = 1; m_done_edge = last + 1;
      end else begin
        m_ready = last + 2;
      end
    end else if (m_run && e > m_seg_lo && e <= m_seg_hi) begin
      if (m_drop < 65535) m_drop++;
    end
  endtask

  // disarm or reset sampled at edge e: no write appears from edge e on
  task automatic model_stop(input int e, input bit is_reset);
    int removed;
    removed = 0;
    while (q.size() > 0 && q[q.size()-1].e >= e) begin
      void'(q.pop_back());
      removed++;
    end
    if (is_reset) begin
      model_clear();
    end else if (m_run) begin
      m_words -= removed;
      if (m_seg_hi > 0 && e <= m_seg_hi) begin
        if (m_seg_cnt) m_segs--;
        if (m_seg_full) m_full = 0;
      end
      m_run = 0; m_fin = 0;
    end
  endtask

  // monitor: every write must match the head of the scoreboard
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    #1;
    if (q.size() > 0 && q[0].e == edge_n) begin
      mon_w = q.pop_front();
      chk("wren_expected", int'(wren), 1);
      chk("waddr", int'(waddr), mon_w.a);
    end else if (wren) begin
      chk("unexpected_wren", int'(wren), 0);
    end
  end

  task automatic check_status(input string tag);
    chk({tag, ".words"},   int'(words),   m_words);
    chk({tag, ".seg_idx"}, int'(seg_idx), m_segs);
    chk({tag, ".done"},    int'(done),    int'(m_run && m_fin));
    chk({tag, ".busy"},    int'(busy),    int'(m_run && !m_fin));
    chk({tag, ".full"},    int'(full),    int'(m_full));
    chk({tag, ".waddr"},   int'(waddr),   (m_words == 0) ? 0 : ((m_words - 1) & MAXA));
`ifdef SPY_TRIG_DROP_CNT_EN
    chk({tag, ".drop_cnt"}, int'(drop_cnt), m_drop);
`endif
  endtask

  task automatic do_arm(input int d, input int dep, input int ns);
    arm = 1'b1;
    trig_delay = CNT_W'(d); seg_depth = CNT_W'(dep); num_seg = SEG_W'(ns);
    model_arm(edge_n + 1, d, dep, ns);
    @(negedge clk);
    arm = 1'b0;
    // later changes must not affect the latched run
    trig_delay = CNT_W'($urandom); seg_depth = CNT_W'($urandom); num_seg = SEG_W'($urandom);
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    model_stop(edge_n + 1, 1'b0);
    @(negedge clk);
    disarm = 1'b0;
  endtask

  task automatic pulse_trig(input int gap, input bit mid_arm);
    int w;
    w = (gap > 2) ? int'($urandom_range(1, gap - 1)) : 1;
    trig_in = 1'b1;
    model_trig(edge_n + 1);
    repeat (w) @(negedge clk);
    trig_in = 1'b0;
    if (mid_arm && ($urandom_range(0, 3) == 0) && (gap - w) >= 1) begin
      do_arm($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 4));
      repeat (gap - w - 1) @(negedge clk);
    end else begin
      repeat (gap - w) @(negedge clk);
    end
  endtask

  task automatic settle();
    int n;
    n = 3;
    if (q.size() > 0) n += q[q.size()-1].e - edge_n;
    if (m_run && m_fin && m_done_edge > edge_n) n += m_done_edge - edge_n;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_capture(input int d, input int dep, input int ns, input int ntrig,
                             input int glo, input int ghi, input bit mid,
                             input int exp_words, input int exp_seg);
    do_arm(d, dep, ns);
    check_status("armed");
    repeat ($urandom_range(0, 2)) @(negedge clk);
    for (int i = 0; i < ntrig; i++) pulse_trig($urandom_range(glo, ghi), mid);
    settle();
    check_status("run");
    if (exp_words >= 0) chk("plan_words", int'(words), exp_words);
    if (exp_seg >= 0) chk("plan_seg_idx", int'(seg_idx), exp_seg);
    if (m_run && !m_fin) begin
      do_disarm();
      check_status("cleanup");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: edge %0d reached time limit", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset = 1'b1; arm = 1'b0; disarm = 1'b0; trig_in = 1'b0;
    trig_delay = '0; seg_depth = '0; num_seg = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_wren", int'(wren), 0);
    check_status("reset");

    // single segment, no delay
    run_capture(0, 4, 1, 1, 4, 4, 0, 4, 1);
    // delay and three segments
    run_capture(5, 3, 3, 3, 20, 20, 0, 9, 3);

    // dropped trigger during WRITE, next one captured
    do_arm(2, 8, 2);
    pulse_trig(5, 0);
    pulse_trig(20, 0);
    pulse_trig(5, 0);
    settle();
    check_status("drop");
    chk("drop_words", int'(words), 16);
`ifdef SPY_TRIG_DROP_CNT_EN
    chk("drop_count", int'(drop_cnt), 1);
`endif

    // full: second segment stops at the last address
    run_capture(0, 10, 3, 3, 20, 20, 0, 16, 1);
    chk("full_flag", int'(full), 1);
    chk("full_waddr", int'(waddr), MAXA);

    // disarm after the third write
    do_arm(0, 8, 1);
    trig_in = 1'b1;
    t = edge_n + 1;
    model_trig(t);
    @(negedge clk);
    trig_in = 1'b0;
    while (edge_n < t + 3) @(negedge clk);
    do_disarm();
    chk("disarm_wren", int'(wren), 0);
    chk("disarm_words", int'(words), 3);
    chk("disarm_done", int'(done), 0);
    check_status("disarm");
    do_arm(1, 4, 2);
    chk("rearm_waddr", int'(waddr), 0);
    chk("rearm_words", int'(words), 0);
    check_status("rearm");
    do_disarm();

    // invalid arms are ignored
    do_arm(1, 0, 2);
    chk("bad_arm_busy", int'(busy), 0);
    do_arm(1, 3, 0);
    chk("bad_arm2_busy", int'(busy), 0);
    check_status("bad_arm");

    // reset during WRITE
    do_arm(0, 8, 1);
    trig_in = 1'b1;
    t = edge_n + 1;
    model_trig(t);
    @(negedge clk);
    trig_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_stop(edge_n + 1, 1'b1);
    @(negedge clk);
    chk("rst_wren", int'(wren), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_words", int'(words), 0);
    check_status("mid_reset");
    reset = 1'b0;
    @(negedge clk);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      run_capture($urandom_range(0, 6), $urandom_range(1, 9), $urandom_range(1, 4),
                  $urandom_range(1, 5), 2, 16, 1'b1, -1, -1);
    end

    settle();
    chk("pending_writes", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spy_seg_capture.md
Name: spy_seg_capture

Overview:
- Parametrised, multi-segment successor to the single-segment spy write controller.
- After an arm command, the block captures up to num_seg triggered segments into one linear spy RAM.
- Each segment begins trig_delay cycles after a trigger rising edge and writes seg_depth consecutive words.
- It sits between the trigger distribution and the spy RAM write port; status outputs go to the register/readout interface.

Parameters:
ADDR_W, 10, spy RAM address width (depth 2^ADDR_W)
CNT_W, 10, width of trig_delay and seg_depth
SEG_W, 4, width of num_seg and seg_idx

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
arm  in  1  start a capture run (one-cycle pulse)
disarm  in  1  abort the run (one-cycle pulse)
trig_in  in  1  trigger level; rising edge is used
trig_delay  in  CNT_W  cycles from trigger to first write; latched at arm
seg_depth  in  CNT_W  words per segment; latched at arm
num_seg  in  SEG_W  segments per run; latched at arm
wren  out  1  RAM write enable (registered)
waddr  out  ADDR_W  RAM write address (registered)
seg_idx  out  SEG_W  number of completed segments
words  out  ADDR_W+1  total words written in the run
busy  out  1  high in states ARMED, DELAY and WRITE
done  out  1  run completed normally or stopped on full
full  out  1  RAM end reached

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs): state=IDLE, wren=0, waddr=0, seg_idx=0, words=0, busy=0, done=0, full=0, trig_d=0.
- Edge detect: trig_d is trig_in registered. A trigger is trig_in=1 && trig_d=0.
- IDLE or DONE, arm=1:
  - Latch trig_delay, seg_depth and num_seg.
  - Clear waddr, words, seg_idx, done and full.
  - Go to ARMED.
  - If the seg_depth input or the num_seg input is 0, ignore arm and remain in the current state.
- arm in ARMED, DELAY or WRITE: ignored.
- ARMED:
  - Trigger with latched delay=0 -> WRITE.
  - Trigger with delay>0 -> DELAY, delay_cnt=1.
- DELAY:
  - delay_cnt==delay -> WRITE.
  - Otherwise delay_cnt+1.
  - Latency: the first wren=1 cycle is exactly delay+1 cycles after the clock edge that sampled the trigger.
- WRITE:
  - wren=1 each cycle at address waddr.
  - After each write: waddr+1, words+1, mem_cnt+1.
  - Exactly seg_depth writes occur, back to back, at contiguous addresses.
- Segment end: on the cycle after the last write, wren=0 and seg_idx+1.
  - If seg_idx reaches num_seg -> DONE with done=1.
  - Otherwise -> ARMED.
- Full: a write to address 2^ADDR_W-1 is the final write.
  - Set full=1 and done=1, go to DONE.
  - waddr saturates at 2^ADDR_W-1; there is no wrap.
  - words = 2^ADDR_W.
  - seg_idx increments only if that write also completed the segment.
- Dropped triggers:
  - Triggers in IDLE, DELAY, WRITE or DONE are dropped.
  - A trigger on the same cycle as the transition back to ARMED is dropped, because it is sampled before ARMED is entered.
  - No retrigger and no queueing.
- disarm:
  - From any state except IDLE: go to IDLE next cycle, wren=0.
  - waddr, words and seg_idx are held for readout; done=0.
  - disarm takes priority over arm and trigger on the same cycle.
- busy is registered and matches the state.
- done is held until arm or reset.
- Inputs changed during a run have no effect until the next arm.

Optional Feature:
- Macro SPY_TRIG_DROP_CNT_EN.
- Defined:
  - Add output drop_cnt, width 16.
  - Increment on each trigger edge seen in DELAY or WRITE; saturate at 16'hFFFF.
  - Cleared by reset and by an accepted arm.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single segment, no delay:
  - Stimulus: arm with delay=0, depth=4, nseg=1; trigger edge sampled at edge n.
  - Response: wren=1 for edges n+1..n+4 at waddr 0..3; then done=1, words=4, seg_idx=1, busy=0.
- Delay and multiple segments:
  - Stimulus: delay=5, depth=3, nseg=3; three triggers spaced 20 cycles apart.
  - Response: each first write occurs 6 cycles after its trigger; addresses 0..8 are contiguous; done after the 9th write; words=9.
- Dropped trigger:
  - Stimulus: delay=2, depth=8, nseg=2; second trigger arrives during WRITE, third while ARMED.
  - Response: the second is ignored and the third captured; words=16. With SPY_TRIG_DROP_CNT_EN, drop_cnt=1.
- Full:
  - Stimulus: ADDR_W=4, depth=10, nseg=3, delay=0.
  - Response: the second segment stops after address 15; full=1, done=1, words=16, seg_idx=1, waddr=15, and no further writes occur.
- Disarm mid-segment:
  - Stimulus: depth=8; assert disarm after the 3rd write.
  - Response: wren=0 next cycle, state IDLE, words=3, done=0.
  - Follow-up: arm again -> waddr=0, words=0.
- Invalid arm and reset:
  - Stimulus: arm with depth=0.
  - Response: stays IDLE, busy=0.
  - Stimulus: reset during WRITE.
  - Response: all outputs return to reset values on the next edge.
